// File: rtl/mix_columns_iter.sv
// Column-serial AES forward MixColumns engine.
// A 128-bit state is accepted in IDLE, its four 32-bit columns are transformed
// one per clock through a single GF(2^8) column datapath in COMPUTE, and the
// result is presented in DONE until the downstream takes it.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The producer holds data and valid stable until that edge;
// ready never depends combinationally on valid.
module mix_columns_iter #(
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] in_state,
  input  logic                      in_skip,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] out_state,
  output logic                      busy
);

  localparam int STATE_W = NUM_COLS * COL_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         col_q, col_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               skip_q, skip_d;
  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  logic [COL_W-1:0]   col_in, col_out;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column, s0 in the MSB byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] d0, d1, d2, d3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    d0 = xtime(s0);
    d1 = xtime(s1);
    d2 = xtime(s2);
    d3 = xtime(s3);
    return {d0 ^ (d1 ^ s1) ^ s2 ^ s3,
            s0 ^ d1 ^ (d2 ^ s2) ^ s3,
            s0 ^ s1 ^ d2 ^ (d3 ^ s3),
            (d0 ^ s0) ^ s1 ^ s2 ^ d3};
  endfunction

  // Select the column addressed by the counter; column 0 is the top word.
  always_comb begin
    col_in = work_q[127:96];
    case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
  end

  // The skip path still takes the full four column steps so latency is fixed.
  always_comb begin
    col_out = skip_q ? col_in : mix_col(col_in);
  end

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    skip_d      = skip_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          skip_d  = in_skip;
          col_d   = 2'd0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        case (col_q)
          2'd0: work_d[127:96] = col_out;
          2'd1: work_d[95:64]  = col_out;
          2'd2: work_d[63:32]  = col_out;
          2'd3: work_d[31:0]   = col_out;
          default: work_d = work_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          // Separate output register keeps out_state steady after the block
          // leaves, even once the work register is reloaded.
          out_state_d = work_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      skip_q      <= skip_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed and random bench for the column-serial MixColumns engine.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_skip;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] orig_q[$];
  logic         skip_q[$];

  mix_columns_iter #(.NUM_COLS(4), .COL_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_skip   (in_skip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] col_mul(input logic [31:0] c, input logic [7:0] m0,
                                          input logic [7:0] m1, input logic [7:0] m2,
                                          input logic [7:0] m3);
    logic [7:0] s [4];
    logic [7:0] m [4];
    logic [31:0] r;
    s[0] = c[31:24]; s[1] = c[23:16]; s[2] = c[15:8]; s[3] = c[7:0];
    m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(s[k], m[(k - row + 4) % 4]);
      r[31 - 8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] mc_state(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = col_mul(s[127 - 32*c -: 32], 8'h02, 8'h03, 8'h01, 8'h01);
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = col_mul(s[127 - 32*c -: 32], 8'h0e, 8'h0b, 8'h0d, 8'h09);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present a block after a random gap, push its expectation when taken
  task automatic send(input logic [127:0] s, input logic k, input logic [127:0] exp, input int pre);
    int n;
    @(negedge clk);
    repeat ($urandom_range(pre, 0)) @(negedge clk);
    in_valid = 1'b1;
    in_state = s;
    in_skip  = k;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(exp);
    orig_q.push_back(s);
    skip_q.push_back(k);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_timeout"}, out_valid, 1'b1);
  endtask

  // scoreboard side: stall, then take the output and compare against the queue
  task automatic recv(input string tag, input int stall_max);
    logic [127:0] held;
    logic [127:0] e;
    logic [127:0] o;
    logic         k;
    wait_valid(tag);
    held = out_state;
    repeat ($urandom_range(stall_max, 0)) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, out_valid, 1'b1);
      check({tag, "_stall_data"}, out_state, held);
      check({tag, "_stall_in_ready"}, in_ready, 1'b0);
    end
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = orig_q.pop_front();
      k = skip_q.pop_front();
      check({tag, "_data"}, out_state, e);
      if (!k) check({tag, "_inverse"}, inv_state(out_state), o);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] fips_in, fips_out, v2_in, v2_out, skip_in, rnd, held;
    fips_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    fips_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    v2_in    = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    v2_out   = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    skip_in  = 128'h00112233_44556677_8899aabb_ccddeeff;

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_skip = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_out_state", out_state, '0);
    rst = 1'b0;

    // FIPS-197 vector with exact latency
    send(fips_in, 1'b0, fips_out, 0);
    check("fips_busy", busy, 1'b1);
    check("fips_in_ready", in_ready, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("fips_early_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    check("fips_valid_at_4", out_valid, 1'b1);
    recv("fips", 0);
    check("fips_idle_busy", busy, 1'b0);

    // second vector
    send(v2_in, 1'b0, v2_out, 2);
    recv("v2", 2);

    // skip passes through with the same latency
    send(skip_in, 1'b1, skip_in, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("skip_early_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    check("skip_valid_at_4", out_valid, 1'b1);
    recv("skip", 0);

    // backpressure with a second block waiting upstream
    send(v2_in, 1'b0, v2_out, 0);
    wait_valid("bp");
    held = out_state;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_state = rnd; in_skip = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_state, held);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_busy", busy, 1'b1);
    end
    check("bp_result", out_state, exp_q.pop_front());
    void'(orig_q.pop_front());
    void'(skip_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_valid", out_valid, 1'b0);
    check("bp_after_busy", busy, 1'b0);
    check("bp_after_in_ready", in_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back(mc_state(rnd));
    orig_q.push_back(rnd);
    skip_q.push_back(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", busy, 1'b1);
    recv("bp_second", 3);

    // reset during COMPUTE abandons the block
    send(v2_in, 1'b0, v2_out, 0);
    void'(exp_q.pop_back());
    void'(orig_q.pop_back());
    void'(skip_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_mid_no_output", out_valid, 1'b0);
    end
    out_ready = 1'b0;
    send(fips_in, 1'b0, fips_out, 0);
    recv("rst_after", 1);

    // random blocks with random upstream gaps and downstream stalls
    for (int i = 0; i < 1000; i++) begin
      logic k;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      k   = ($urandom_range(7, 0) == 0);
      send(rnd, k, k ? rnd : mc_state(rnd), 3);
      recv("rand", 3);
    end

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
